// File: rtl/fc_layer_scheduler.sv
// Walks a preloaded descriptor table and launches the matrix_fc engine once per layer,
// ping-ponging activations between two buffers. Optional perf counters: FC_SCHED_PERF_EN.
module fc_layer_scheduler #(
  parameter int          MAX_LAYERS = 8,
  parameter int          LW         = 3,
  parameter logic [13:0] BUF_A_ADDR = 14'd0,
  parameter logic [13:0] BUF_B_ADDR = 14'd4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [LW-1:0] cfg_layer,
  input  logic [1:0]    cfg_field,
  input  logic [13:0]   cfg_data,
  output logic          cfg_err,
  input  logic [LW:0]   num_layers,
  input  logic          run_start,
  input  logic          abort,
  output logic          busy,
  output logic          run_done,
  output logic [LW-1:0] cur_layer,
  output logic          out_buf_sel,
  output logic          eng_start,
  input  logic          eng_done,
  output logic [13:0]   eng_src1_addr,
  output logic [13:0]   eng_src2_addr,
  output logic [13:0]   eng_dest_addr,
  output logic [12:0]   eng_src1_row,
  output logic [12:0]   eng_src1_col,
  output logic [12:0]   eng_src2_row,
  output logic [12:0]   eng_src2_col
`ifdef FC_SCHED_PERF_EN
  ,
  output logic [31:0]   perf_cycles,
  output logic [LW:0]   perf_layers
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LAUNCH, S_WAIT, S_NEXT, S_FINISH} state_t;

  localparam logic [LW:0] LAYER_ONE = (LW+1)'(1);
  localparam logic [LW:0] LAYER_MAX = (LW+1)'(MAX_LAYERS);

  state_t      state_reg, state_next;
  logic [LW:0] layer_reg, layer_next, n_reg, n_next;
  logic        parity_reg, parity_next, abort_reg, abort_next;
  logic        busy_reg, busy_next, run_done_reg, run_done_next;
  logic        obs_reg, obs_next, cfg_err_reg, cfg_err_next;
  logic        start_reg, start_next;
  logic [13:0] src1_reg, src1_next, src2_reg, src2_next, dest_reg, dest_next;
  logic [12:0] row1_reg, row1_next, row2_reg, row2_next, col2_reg, col2_next;

  // Descriptor table: deliberately not reset, only written while idle
  logic [13:0] w_mem   [MAX_LAYERS];
  logic [12:0] in_mem  [MAX_LAYERS];
  logic [12:0] out_mem [MAX_LAYERS];

  always_ff @(posedge clk) begin
    if (cfg_we && state_reg == S_IDLE) begin
      case (cfg_field)
        2'd0:    w_mem[cfg_layer]   <= cfg_data;
        2'd1:    in_mem[cfg_layer]  <= cfg_data[12:0];
        2'd2:    out_mem[cfg_layer] <= cfg_data[12:0];
        default: ;
      endcase
    end
  end

  logic [13:0] d_w;
  logic [12:0] d_in, d_out;
  assign d_w   = w_mem[layer_reg[LW-1:0]];
  assign d_in  = in_mem[layer_reg[LW-1:0]];
  assign d_out = out_mem[layer_reg[LW-1:0]];

  always_comb begin
    state_next    = state_reg;
    layer_next    = layer_reg;
    n_next        = n_reg;
    parity_next   = parity_reg;
    abort_next    = abort_reg | (abort && state_reg != S_IDLE);
    busy_next     = busy_reg;
    run_done_next = 1'b0;
    obs_next      = obs_reg;
    cfg_err_next  = cfg_we && state_reg != S_IDLE;
    start_next    = start_reg;
    src1_next     = src1_reg;
    src2_next     = src2_reg;
    dest_next     = dest_reg;
    row1_next     = row1_reg;
    row2_next     = row2_reg;
    col2_next     = col2_reg;
    case (state_reg)
      S_IDLE: begin
        abort_next = 1'b0;
        if (run_start) begin
          n_next      = (num_layers > LAYER_MAX) ? LAYER_MAX : num_layers;
          layer_next  = '0;
          parity_next = 1'b0;
          busy_next   = 1'b1;
          state_next  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (layer_reg == n_reg) begin
          state_next = S_FINISH;
        end else if (d_in == '0 || d_out == '0) begin
          layer_next = layer_reg + LAYER_ONE;
        end else begin
          src1_next  = parity_reg ? BUF_B_ADDR : BUF_A_ADDR;
          dest_next  = parity_reg ? BUF_A_ADDR : BUF_B_ADDR;
          src2_next  = d_w;
          row1_next  = d_in;
          row2_next  = d_out;
          col2_next  = d_in;
          start_next = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      // Engine idles with done high, so only a low done proves the job was taken
      S_LAUNCH: begin
        if (!eng_done) begin
          start_next = 1'b0;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_done) state_next = S_NEXT;
      end
      S_NEXT: begin
        layer_next  = layer_reg + LAYER_ONE;
        parity_next = ~parity_reg;
        state_next  = (abort_reg || abort) ? S_FINISH : S_SETUP;
      end
      S_FINISH: begin
        run_done_next = 1'b1;
        obs_next      = parity_reg;
        busy_next     = 1'b0;
        abort_next    = 1'b0;
        state_next    = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      layer_reg    <= '0;
      n_reg        <= '0;
      parity_reg   <= 1'b0;
      abort_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      run_done_reg <= 1'b0;
      obs_reg      <= 1'b0;
      cfg_err_reg  <= 1'b0;
      start_reg    <= 1'b0;
      src1_reg     <= '0;
      src2_reg     <= '0;
      dest_reg     <= '0;
      row1_reg     <= '0;
      row2_reg     <= '0;
      col2_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      layer_reg    <= layer_next;
      n_reg        <= n_next;
      parity_reg   <= parity_next;
      abort_reg    <= abort_next;
      busy_reg     <= busy_next;
      run_done_reg <= run_done_next;
      obs_reg      <= obs_next;
      cfg_err_reg  <= cfg_err_next;
      start_reg    <= start_next;
      src1_reg     <= src1_next;
      src2_reg     <= src2_next;
      dest_reg     <= dest_next;
      row1_reg     <= row1_next;
      row2_reg     <= row2_next;
      col2_reg     <= col2_next;
    end
  end

`ifdef FC_SCHED_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_layers <= '0;
    end else if (state_reg == S_IDLE && run_start) begin
      perf_cycles <= '0;
      perf_layers <= '0;
    end else begin
      if (busy_reg) perf_cycles <= perf_cycles + 32'd1;
      if (state_reg == S_WAIT && eng_done) perf_layers <= perf_layers + LAYER_ONE;
    end
  end
`endif

  assign cfg_err       = cfg_err_reg;
  assign busy          = busy_reg;
  assign run_done      = run_done_reg;
  assign cur_layer     = layer_reg[LW-1:0];
  assign out_buf_sel   = obs_reg;
  assign eng_start     = start_reg;
  assign eng_src1_addr = src1_reg;
  assign eng_src2_addr = src2_reg;
  assign eng_dest_addr = dest_reg;
  assign eng_src1_row  = row1_reg;
  assign eng_src1_col  = 13'd1;
  assign eng_src2_row  = row2_reg;
  assign eng_src2_col  = col2_reg;

endmodule

// File: doc/fc_layer_scheduler.md
Name: fc_layer_scheduler

Overview:
- Sequences a chain of fully-connected layers through the single matrix_fc engine.
- Host preloads a small descriptor table (weight address, input length, output length per layer), then pulses run_start.
- The scheduler configures and launches the engine once per layer, ping-ponging activations between two fixed buffers, and reports completion.
- Sits between the host/control bus and the matrix_fc engine.

Parameters:
- MAX_LAYERS, 8, descriptor table depth; must be a power of 2.
- LW, 3, layer index width, equal to log2(MAX_LAYERS).
- BUF_A_ADDR, 14'd0, activation buffer A base. Network input lives here.
- BUF_B_ADDR, 14'd4096, activation buffer B base.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- cfg_we  input  1  descriptor write strobe
- cfg_layer  input  LW  descriptor index
- cfg_field  input  2  0=w_addr[13:0], 1=in_len[12:0], 2=out_len[12:0], 3=reserved (ignored)
- cfg_data  input  14  write data; 13-bit fields use bits [12:0]
- cfg_err  output  1  one-cycle pulse: write rejected because busy
- num_layers  input  LW+1  layers to run (0..MAX_LAYERS), sampled on run_start
- run_start  input  1  start pulse, accepted only in IDLE
- abort  input  1  stop after current engine job
- busy  output  1  high from the cycle after run_start until FINISH
- run_done  output  1  one-cycle pulse at end of run
- cur_layer  output  LW  index of the layer in progress
- out_buf_sel  output  1  buffer holding the final result: 0=A, 1=B; valid at run_done
- eng_start  output  1  engine start
- eng_done  input  1  engine done level: high while the engine is idle, low while computing
- eng_src1_addr  output  14  activation source base
- eng_src2_addr  output  14  weight base
- eng_dest_addr  output  14  activation destination base
- eng_src1_row  output  13  =in_len
- eng_src1_col  output  13  =1
- eng_src2_row  output  13  =out_len
- eng_src2_col  output  13  =in_len

Behaviour:
- Reset values: all outputs 0; eng_src1_col=1; state IDLE.
- Descriptor table is not reset; its contents are undefined until written.
- Descriptor writes:
  - Accepted in IDLE only; take effect the next cycle.
  - A write while busy is dropped and pulses cfg_err on the next cycle.
- All outputs are registered.
- State IDLE: on run_start, latch N=num_layers, set layer=0, set parity=0, then go to SETUP.
- State SETUP:
  - If layer==N, go to FINISH.
  - If in_len==0 or out_len==0, the layer is skipped: layer+1, parity unchanged, stay in SETUP.
  - Otherwise drive the engine config from descriptor[layer], then go to LAUNCH.
  - Parity 0: src1=BUF_A_ADDR, dest=BUF_B_ADDR. Parity 1: the two are swapped.
  - Engine config is held stable from SETUP through WAIT.
- State LAUNCH:
  - eng_start=1. Hold it until eng_done is sampled low, then drop eng_start and go to WAIT.
  - The engine holds done high in its own idle state, so a high done is never taken as completion here.
- State WAIT: on eng_done high, go to NEXT.
- State NEXT:
  - layer+1, parity toggles.
  - If abort was seen at any time since SETUP, go to FINISH; otherwise go to SETUP.
- State FINISH:
  - Pulse run_done; out_buf_sel=parity; busy=0; go to IDLE.
  - If no layer ran (N=0 or all layers skipped), out_buf_sel=0 (buffer A).
- num_layers > MAX_LAYERS is clamped to MAX_LAYERS.
- run_start while busy is ignored.
- Minimum per-layer overhead: SETUP + LAUNCH(≥1) + NEXT = 3 cycles plus engine time.
- Reset mid-run: immediate return to IDLE with all outputs cleared. The engine is reset by the same reset, so no job is left dangling.
- abort in IDLE has no effect; an abort latch is cleared on entry to IDLE.

Optional Feature:
- Macro FC_SCHED_PERF_EN.
- When defined, adds these outputs:
  - perf_cycles[31:0]: counts cycles while busy.
  - perf_layers[LW:0]: counts engine jobs completed.
  - Both clear on an accepted run_start, hold after run_done, and reset to 0.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single layer: descriptor[0]={w=0x2000, in=4, out=3}, N=1. Expected:
  - eng_src1_addr=0, eng_dest_addr=4096, eng_src2_row=3, eng_src2_col=4.
  - Exactly one eng_start episode.
  - run_done pulse with out_buf_sel=1.
- Three layers {in=4,out=3},{in=3,out=2},{in=2,out=2}:
  - src1/dest alternate A→B, B→A, A→B.
  - cur_layer goes 0,1,2.
  - out_buf_sel=1.
- Skip and empty runs:
  - N=2 with layer0 out_len=0: only layer1 launched, with src1=BUF_A.
  - N=0: run_done within 3 cycles of run_start, no eng_start, out_buf_sel=0.
- Busy-state writes and starts: cfg_we during WAIT → cfg_err pulse, table unchanged. A second run_start during the run is ignored.
- Abort/reset:
  - abort in layer 0 of a 3-layer run → layer 0 completes, then run_done, no further eng_start.
  - Reset asserted during LAUNCH → eng_start, busy, and cur_layer are 0 in the same cycle.
- Engine handshake: eng_done model held high for 2 cycles after start before dropping → eng_start stays high until done falls. Completion is not declared early.
